lcd_nibble_rx: RTL
==================

Name: lcd_nibble_rx

Overview:
Receive-side model of the HD44780-style 4-bit parallel LCD bus that the LCD controller drives through its enable, RS and data-nibble outputs. The block synchronises the E/RS/D[3:0] pins to its own clock and captures a value on each falling edge of E. It reassembles bytes in both 8-bit (power-on) and 4-bit mode, decodes the cursor-affecting commands, and reports characters with their DDRAM address. It is used as a bus monitor and checker on the FPGA and as the device-side model in controller benches.

Parameters:
TIMEOUT_CYCLES, 24000, max clk cycles allowed between the high and low nibble of a 4-bit byte (2 ms at 12 MHz); minimum 4
SYNC_STAGES, 2, input synchroniser depth; legal values 2 or 3

Ports:
clk  input  1  system clock (12 MHz nominal)
rst  input  1  asynchronous, active-high reset
lcd_en_in  input  1  LCD E pin, asynchronous to clk
lcd_rs_in  input  1  LCD RS pin (0 = command, 1 = data)
lcd_data_in  input  4  LCD D7..D4
byte_valid  output  1  one-cycle pulse: a complete byte was received
byte_data  output  8  received byte; held until the next byte_valid
byte_rs  output  1  RS of the received byte
char_valid  output  1  one-cycle pulse: a data byte (RS=1) was written
char_data  output  8  character code; equals byte_data when char_valid is high
char_addr  output  7  DDRAM address the character was written to
cursor_addr  output  7  current DDRAM address counter
clear_pulse  output  1  one-cycle pulse on a Clear Display command (0x01)
mode_4bit  output  1  1 = 4-bit interface mode active
err_pulse  output  1  one-cycle pulse on a nibble timeout or RS mismatch

Behaviour:
- Reset (async assert, sync deassert internally): all pulses = 0; byte_data = 0; byte_rs = 0; char_data = 0; char_addr = 0; cursor_addr = 0; mode_4bit = 0; increment flag I/D = 1; nibble phase = HIGH; timeout counter = 0; synchroniser flops = 0.
- Synchronisation: E, RS and D each pass through SYNC_STAGES flops. A strobe is the registered-E 1→0 transition. RS and D are sampled from the synchronised copies on the strobe cycle.
- Latency: with the default SYNC_STAGES = 2, if E is low at rising edge k, all result outputs update at edge k+2. Each extra sync stage adds one cycle. E must be high for at least SYNC_STAGES+1 clk cycles to be detected.
- 8-bit mode (mode_4bit = 0): each strobe produces one byte = {D, 4'h0}, with byte_rs = sampled RS.
- 4-bit mode, state machine with states HIGH and LOW:
  - In HIGH, a strobe stores the nibble and RS, clears the counter and moves to LOW. No output is produced.
  - In LOW, a strobe produces byte = {stored, D}.
  - In LOW, if the RS sampled now differs from the stored RS: no byte is produced, err_pulse fires, and the state returns to HIGH.
  - In LOW, the counter increments every cycle. When it reaches TIMEOUT_CYCLES without a strobe: err_pulse fires, the stored nibble is discarded, and the state returns to HIGH. If the timeout and a strobe occur in the same cycle, the strobe wins.
- Command decode (byte_rs = 0), by highest set bit; the decoded effect is registered together with byte_valid:
  - 1xxxxxxx: cursor_addr = byte[6:0].
  - 001xxxxx (function set): mode_4bit = ~byte[4], and the phase is forced to HIGH.
  - 000001xx: I/D = byte[1].
  - 0000001x: cursor_addr = 0.
  - 00000001: cursor_addr = 0, I/D = 1, clear_pulse fires.
  - All other commands (0x00, 0x08–0x1F, 0x40–0x7F) produce byte_valid only.
- Data write (byte_rs = 1): char_valid fires with char_data = byte and char_addr = the pre-update cursor_addr. cursor_addr then steps by ±1 according to I/D, wrapping modulo 128 (0x7F+1 → 0x00, 0x00−1 → 0x7F).
- Switching to 4-bit mode takes effect on the next strobe. A function set 0x2x seen in 8-bit mode switches the block to 4-bit mode. A 0x3x received in 4-bit mode returns it to 8-bit mode.
- Reset mid-byte discards the pending nibble with no err_pulse.
- At most one of char_valid / clear_pulse is high in a cycle. byte_valid accompanies both.

Test Plan:
- Init: after reset, nibbles 3,3,3,2 with RS = 0 → byte_valid ×4 with byte_data 0x30, 0x30, 0x30, 0x20; mode_4bit = 1 after the fourth byte; no err_pulse.
- Characters: in 4-bit mode, nibble pairs 4/8, 6/5, 6/C, 6/C, 6/F with RS = 1 ("Hello") → char_valid ×5 with char_addr 0x00..0x04; cursor_addr = 0x05; each pulse appears 2 cycles after the E fall.
- Commands: 0xC0 → cursor_addr = 0x40; then 0x04 followed by a data 'A' → char_addr = 0x40, cursor_addr = 0x3F; then 0x01 → clear_pulse, cursor_addr = 0, I/D = 1.
- Wrap: 0xFF (set address 0x7F), then data 'x' → char_addr = 0x7F, cursor_addr = 0x00.
- Errors: a lone high nibble followed by TIMEOUT_CYCLES idle cycles → err_pulse with no byte; then pair 4/1 → 0x41 received normally. A pair with RS 1 then 0 → err_pulse, no byte_valid.
- Reset mid-byte: high nibble, then assert rst → all outputs at reset values with no err_pulse; after rst deasserts, mode_4bit = 0 and nibble 3 → byte 0x30.

Source files
------------

// File: rtl/lcd_nibble_rx_if.sv
// Pin-side and result-side signals of the HD44780-style 4-bit LCD bus monitor.
// The master drives the LCD pins; the slave (the receiver) reports what it decoded.
interface lcd_nibble_rx_if;
  logic       lcd_en_in;
  logic       lcd_rs_in;
  logic [3:0] lcd_data_in;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_rs;
  logic       char_valid;
  logic [7:0] char_data;
  logic [6:0] char_addr;
  logic [6:0] cursor_addr;
  logic       clear_pulse;
  logic       mode_4bit;
  logic       err_pulse;

  modport master (
    output lcd_en_in, lcd_rs_in, lcd_data_in,
    input  byte_valid, byte_data, byte_rs, char_valid, char_data, char_addr,
           cursor_addr, clear_pulse, mode_4bit, err_pulse
  );

  modport slave (
    input  lcd_en_in, lcd_rs_in, lcd_data_in,
    output byte_valid, byte_data, byte_rs, char_valid, char_data, char_addr,
           cursor_addr, clear_pulse, mode_4bit, err_pulse
  );
endinterface

// File: rtl/lcd_nibble_rx.sv
// Receive-side model of an HD44780-style LCD bus: synchronises E/RS/D, captures on E fall,
// rebuilds bytes in 8-bit or 4-bit mode and tracks the DDRAM cursor.
module lcd_nibble_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 24000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic           clk,
  input  logic           rst,
  lcd_nibble_rx_if.slave bus
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {ST_HIGH, ST_LOW} phase_t;

  logic [1:0]                   r_rst_pipe;
  logic                         w_rst;
  logic [SYNC_STAGES-1:0]       r_en_sync;
  logic [SYNC_STAGES-1:0]       r_rs_sync;
  logic [SYNC_STAGES-1:0][3:0]  r_d_sync;
  logic                         r_en_prev;
  logic                         w_en_s;
  logic                         w_rs_s;
  logic [3:0]                   w_d_s;
  logic                         w_strobe;

  phase_t                       r_state, w_state_nxt;
  logic [3:0]                   r_hi_nib, w_hi_nib_nxt;
  logic                         r_hi_rs, w_hi_rs_nxt;
  logic [CNT_W-1:0]             r_cnt, w_cnt_nxt;
  logic                         r_inc, w_inc_nxt;

  logic                         w_have_byte;
  logic [7:0]                   w_byte;
  logic                         w_byte_rs;

  logic                         r_byte_valid, w_byte_valid_nxt;
  logic [7:0]                   r_byte_data, w_byte_data_nxt;
  logic                         r_byte_rs, w_byte_rs_nxt;
  logic                         r_char_valid, w_char_valid_nxt;
  logic [7:0]                   r_char_data, w_char_data_nxt;
  logic [6:0]                   r_char_addr, w_char_addr_nxt;
  logic [6:0]                   r_cursor, w_cursor_nxt;
  logic                         r_clear, w_clear_nxt;
  logic                         r_mode4, w_mode4_nxt;
  logic                         r_err, w_err_nxt;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rst_pipe <= 2'b11;
    else     r_rst_pipe <= {r_rst_pipe[0], 1'b0};
  end
  assign w_rst = r_rst_pipe[1];

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_en_sync <= '0;
      r_rs_sync <= '0;
      r_d_sync  <= '0;
      r_en_prev <= 1'b0;
    end else begin
      r_en_sync <= {r_en_sync[SYNC_STAGES-2:0], bus.lcd_en_in};
      r_rs_sync <= {r_rs_sync[SYNC_STAGES-2:0], bus.lcd_rs_in};
      r_d_sync  <= {r_d_sync[SYNC_STAGES-2:0], bus.lcd_data_in};
      r_en_prev <= r_en_sync[SYNC_STAGES-1];
    end
  end

  assign w_en_s   = r_en_sync[SYNC_STAGES-1];
  assign w_rs_s   = r_rs_sync[SYNC_STAGES-1];
  assign w_d_s    = r_d_sync[SYNC_STAGES-1];
  assign w_strobe = r_en_prev & ~w_en_s;

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) r_state <= ST_HIGH;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_hi_nib_nxt     = r_hi_nib;
    w_hi_rs_nxt      = r_hi_rs;
    w_cnt_nxt        = r_cnt;
    w_inc_nxt        = r_inc;
    w_have_byte      = 1'b0;
    w_byte           = 8'h00;
    w_byte_rs        = 1'b0;
    w_err_nxt        = 1'b0;
    w_byte_data_nxt  = r_byte_data;
    w_byte_rs_nxt    = r_byte_rs;
    w_char_valid_nxt = 1'b0;
    w_char_data_nxt  = r_char_data;
    w_char_addr_nxt  = r_char_addr;
    w_cursor_nxt     = r_cursor;
    w_clear_nxt      = 1'b0;
    w_mode4_nxt      = r_mode4;

    // Byte assembly: one strobe per byte in 8-bit mode, high/low nibble pair in 4-bit mode.
    if (!r_mode4) begin
      w_state_nxt = ST_HIGH;
      w_cnt_nxt   = '0;
      if (w_strobe) begin
        w_have_byte = 1'b1;
        w_byte      = {w_d_s, 4'h0};
        w_byte_rs   = w_rs_s;
      end
    end else begin
      case (r_state)
        ST_HIGH: begin
          if (w_strobe) begin
            w_hi_nib_nxt = w_d_s;
            w_hi_rs_nxt  = w_rs_s;
            w_cnt_nxt    = '0;
            w_state_nxt  = ST_LOW;
          end
        end
        ST_LOW: begin
          if (w_strobe) begin
            w_state_nxt = ST_HIGH;
            w_cnt_nxt   = '0;
            if (w_rs_s != r_hi_rs) begin
              w_err_nxt = 1'b1;
            end else begin
              w_have_byte = 1'b1;
              w_byte      = {r_hi_nib, w_d_s};
              w_byte_rs   = w_rs_s;
            end
          end else if (r_cnt == CNT_LAST) begin
            w_err_nxt   = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_HIGH;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: w_state_nxt = ST_HIGH;
      endcase
    end

    // Decode the completed byte: data writes advance the cursor, commands by highest set bit.
    if (w_have_byte) begin
      w_byte_data_nxt = w_byte;
      w_byte_rs_nxt   = w_byte_rs;
      if (w_byte_rs) begin
        w_char_valid_nxt = 1'b1;
        w_char_data_nxt  = w_byte;
        w_char_addr_nxt  = r_cursor;
        w_cursor_nxt     = r_inc ? (r_cursor + 7'd1) : (r_cursor - 7'd1);
      end else begin
        casez (w_byte)
          8'b1???????: w_cursor_nxt = w_byte[6:0];
          8'b001?????: begin
            w_mode4_nxt = ~w_byte[4];
            w_state_nxt = ST_HIGH;
          end
          8'b000001??: w_inc_nxt = w_byte[1];
          8'b0000001?: w_cursor_nxt = 7'd0;
          8'b00000001: begin
            w_cursor_nxt = 7'd0;
            w_inc_nxt    = 1'b1;
            w_clear_nxt  = 1'b1;
          end
          default: ;
        endcase
      end
    end
    w_byte_valid_nxt = w_have_byte;
  end

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_hi_nib     <= 4'h0;
      r_hi_rs      <= 1'b0;
      r_cnt        <= '0;
      r_inc        <= 1'b1;
      r_byte_valid <= 1'b0;
      r_byte_data  <= 8'h00;
      r_byte_rs    <= 1'b0;
      r_char_valid <= 1'b0;
      r_char_data  <= 8'h00;
      r_char_addr  <= 7'd0;
      r_cursor     <= 7'd0;
      r_clear      <= 1'b0;
      r_mode4      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_hi_nib     <= w_hi_nib_nxt;
      r_hi_rs      <= w_hi_rs_nxt;
      r_cnt        <= w_cnt_nxt;
      r_inc        <= w_inc_nxt;
      r_byte_valid <= w_byte_valid_nxt;
      r_byte_data  <= w_byte_data_nxt;
      r_byte_rs    <= w_byte_rs_nxt;
      r_char_valid <= w_char_valid_nxt;
      r_char_data  <= w_char_data_nxt;
      r_char_addr  <= w_char_addr_nxt;
      r_cursor     <= w_cursor_nxt;
      r_clear      <= w_clear_nxt;
      r_mode4      <= w_mode4_nxt;
      r_err        <= w_err_nxt;
    end
  end

  assign bus.byte_valid  = r_byte_valid;
  assign bus.byte_data   = r_byte_data;
  assign bus.byte_rs     = r_byte_rs;
  assign bus.char_valid  = r_char_valid;
  assign bus.char_data   = r_char_data;
  assign bus.char_addr   = r_char_addr;
  assign bus.cursor_addr = r_cursor;
  assign bus.clear_pulse = r_clear;
  assign bus.mode_4bit   = r_mode4;
  assign bus.err_pulse   = r_err;

endmodule
